trap_ctrl: RTL and testbench

- Trap/exception sequencer that sits directly upstream of the CSR unit.
- Collects synchronous exception flags from the datapath, the timer interrupt request from the CSR unit, and MRET/WFI decode.
- At each instruction boundary, decides whether a trap is taken. If so, it drives the CSR unit's trap-entry inputs (jump strobe, cause, tval, faulting PC) and redirects/flushes the fetch path.
- Also owns the WFI stall and the MRET return redirect.

---
 rtl/trap_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/exception sequencer feeding the CSR unit: picks the trap at each
// instruction boundary, drives trap-entry info, and owns the MRET redirect and WFI stall.
module trap_ctrl #(
  parameter bit          VECTORED = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      next_pc_i,
  input  logic             exc_fetch_misalign_i,
  input  logic             exc_illegal_i,
  input  logic             exc_ebreak_i,
  input  logic             exc_ecall_i,
  input  logic             exc_load_misalign_i,
  input  logic             exc_store_misalign_i,
  input  logic [31:0]      bad_addr_i,
  input  logic             mret_i,
  input  logic             wfi_i,
  input  logic             mtime_exc_i,
  input  logic [31:0]      mtvec_i,
  input  logic [31:0]      mepc_i,
  output logic             jumping_to_mtvec_o,
  output logic [31:0]      exc_cause_o,
  output logic [31:0]      trap_info_o,
  output logic [31:0]      trap_pc_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] trap_count_o
);

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] CAUSE_MTI  = 32'h8000_0007;
  localparam logic [31:0] IRQ_OFFSET = 32'd28;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_WFI} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   resume_pc;
  logic              wfi_enter;
  logic              is_irq;
  logic [XLEN-1:0]   mtvec_base;

  assign mtvec_base = {mtvec_i[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Decision logic: zero-latency so the CSR unit captures on the retiring edge.
  always_comb begin
    state_nxt          = state;
    jumping_to_mtvec_o = 1'b0;
    exc_cause_o        = '0;
    trap_info_o        = '0;
    trap_pc_o          = '0;
    redirect_o         = 1'b0;
    redirect_pc_o      = '0;
    flush_o            = 1'b0;
    stall_o            = 1'b0;
    wfi_enter          = 1'b0;
    is_irq             = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (instr_valid_i) begin
          jumping_to_mtvec_o = 1'b1;
          trap_pc_o          = pc_i;
          if (mtime_exc_i) begin
            exc_cause_o = CAUSE_MTI;
            is_irq      = 1'b1;
          end else if (exc_fetch_misalign_i) begin
            exc_cause_o = 32'd0;
            trap_info_o = bad_addr_i;
          end else if (exc_illegal_i) begin
            exc_cause_o = 32'd2;
            trap_info_o = instr_i;
          end else if (exc_ebreak_i) begin
            exc_cause_o = 32'd3;
            trap_info_o = pc_i;
          end else if (exc_ecall_i) begin
            exc_cause_o = 32'd11;
          end else if (exc_load_misalign_i) begin
            exc_cause_o = 32'd4;
            trap_info_o = bad_addr_i;
          end else if (exc_store_misalign_i) begin
            exc_cause_o = 32'd6;
            trap_info_o = bad_addr_i;
          end else begin
            jumping_to_mtvec_o = 1'b0;
            trap_pc_o          = '0;
            if (mret_i) begin
              redirect_o    = 1'b1;
              flush_o       = 1'b1;
              redirect_pc_o = mepc_i;
              state_nxt     = ST_FLUSH;
            end else if (wfi_i) begin
              wfi_enter = 1'b1;
              state_nxt = ST_WFI;
            end
          end
        end
      end
      ST_FLUSH: begin
        flush_o   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_WFI: begin
        if (mtime_exc_i) begin
          jumping_to_mtvec_o = 1'b1;
          exc_cause_o        = CAUSE_MTI;
          trap_pc_o          = resume_pc;
          is_irq             = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (jumping_to_mtvec_o) begin
      redirect_o    = 1'b1;
      flush_o       = 1'b1;
      redirect_pc_o = (VECTORED && is_irq) ? mtvec_base + IRQ_OFFSET : mtvec_base;
      state_nxt     = ST_FLUSH;
    end

    // Hold everything quiet while reset is asserted.
    if (rst) begin
      jumping_to_mtvec_o = 1'b0;
      exc_cause_o        = '0;
      trap_info_o        = '0;
      trap_pc_o          = '0;
      redirect_o         = 1'b0;
      redirect_pc_o      = '0;
      flush_o            = 1'b0;
      stall_o            = 1'b0;
      wfi_enter          = 1'b0;
    end
  end

  // Resume address for a WFI woken by the timer interrupt.
  always_ff @(posedge clk) begin
    if (rst)            resume_pc <= '0;
    else if (wfi_enter) resume_pc <= next_pc_i;
  end

  always_ff @(posedge clk) begin
    if (rst)
      trap_count_o <= '0;
    else if (jumping_to_mtvec_o && (trap_count_o != {CNT_W{1'b1}}))
      trap_count_o <= trap_count_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a vectored 2-bit-counter instance and a
// non-vectored 16-bit-counter instance share all stimulus.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic [31:0] pc_i, instr_i, next_pc_i, bad_addr_i, mtvec_i, mepc_i;
  logic        exc_fetch_misalign_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
  logic        exc_load_misalign_i, exc_store_misalign_i;
  logic        mret_i, wfi_i, mtime_exc_i;

  logic        jump, redir, flush, stall;
  logic [31:0] cause, tval, tpc, rpc;
  logic [1:0]  cnt;
  logic        jump0, redir0, flush0, stall0;
  logic [31:0] cause0, tval0, tpc0, rpc0;
  logic [15:0] cnt0;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt  = 0;
  int exp_cnt0 = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED(1'b1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .next_pc_i(next_pc_i), .exc_fetch_misalign_i(exc_fetch_misalign_i),
    .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i), .exc_ecall_i(exc_ecall_i),
    .exc_load_misalign_i(exc_load_misalign_i), .exc_store_misalign_i(exc_store_misalign_i),
    .bad_addr_i(bad_addr_i), .mret_i(mret_i), .wfi_i(wfi_i), .mtime_exc_i(mtime_exc_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .jumping_to_mtvec_o(jump), .exc_cause_o(cause),
    .trap_info_o(tval), .trap_pc_o(tpc), .redirect_o(redir), .redirect_pc_o(rpc),
    .flush_o(flush), .stall_o(stall), .trap_count_o(cnt));

  trap_ctrl #(.VECTORED(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .next_pc_i(next_pc_i), .exc_fetch_misalign_i(exc_fetch_misalign_i),
    .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i), .exc_ecall_i(exc_ecall_i),
    .exc_load_misalign_i(exc_load_misalign_i), .exc_store_misalign_i(exc_store_misalign_i),
    .bad_addr_i(bad_addr_i), .mret_i(mret_i), .wfi_i(wfi_i), .mtime_exc_i(mtime_exc_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .jumping_to_mtvec_o(jump0), .exc_cause_o(cause0),
    .trap_info_o(tval0), .trap_pc_o(tpc0), .redirect_o(redir0), .redirect_pc_o(rpc0),
    .flush_o(flush0), .stall_o(stall0), .trap_count_o(cnt0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    instr_valid_i = 0; exc_fetch_misalign_i = 0; exc_illegal_i = 0; exc_ebreak_i = 0;
    exc_ecall_i = 0; exc_load_misalign_i = 0; exc_store_misalign_i = 0;
    mret_i = 0; wfi_i = 0; mtime_exc_i = 0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1-2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt"},  32'(cnt),  32'(exp_cnt));
    check({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt0));
  endtask

  // Check a taken trap this cycle, then clock it and check the counters.
  task automatic trap_cycle(input string tag, input logic [31:0] ecause, input logic [31:0] etval,
                            input logic [31:0] etpc, input logic [31:0] erpc, input logic [31:0] erpc0);
    #1;
    check({tag, "_jump"},  32'(jump),  32'd1);
    check({tag, "_redir"}, 32'(redir), 32'd1);
    check({tag, "_flush"}, 32'(flush), 32'd1);
    check({tag, "_cause"}, cause, ecause);
    check({tag, "_tval"},  tval,  etval);
    check({tag, "_tpc"},   tpc,   etpc);
    check({tag, "_rpc"},   rpc,   erpc);
    check({tag, "_rpc0"},  rpc0,  erpc0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    exp_cnt0++;
    if (exp_cnt < 3) exp_cnt++;
    tick();
    check_counts(tag);
  endtask

  // FLUSH bubble: strobes quiet except flush, flags ignored.
  task automatic flush_cycle(input string tag);
    #1;
    check({tag, "_fl_flush"}, 32'(flush), 32'd1);
    check({tag, "_fl_jump"},  32'(jump),  32'd0);
    check({tag, "_fl_redir"}, 32'(redir), 32'd0);
    check({tag, "_fl_cause"}, cause, 32'd0);
    tick();
  endtask

  initial begin
    clear_in();
    pc_i = 0; instr_i = 0; next_pc_i = 0; bad_addr_i = 0; mtvec_i = 0; mepc_i = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_jump",  32'(jump),  32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rpc",   rpc, 32'd0);
    check_counts("rst");
    tick();

    // Illegal instruction; flags stay high through the bubble.
    instr_valid_i = 1; exc_illegal_i = 1; pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; mtvec_i = 32'h200;
    trap_cycle("illegal", 32'd2, 32'hFFFF_FFFF, 32'h100, 32'h200, 32'h200);
    flush_cycle("illegal");
    clear_in();

    // Interrupt beats ECALL; vectored offset only on dut.
    instr_valid_i = 1; mtime_exc_i = 1; exc_ecall_i = 1; pc_i = 32'h40; mtvec_i = 32'h301;
    trap_cycle("irq_ecall", 32'h8000_0007, 32'd0, 32'h40, 32'h31C, 32'h300);
    clear_in();
    flush_cycle("irq_ecall");

    instr_valid_i = 1; exc_ecall_i = 1; pc_i = 32'h44; mtvec_i = 32'h200;
    trap_cycle("ecall", 32'd11, 32'd0, 32'h44, 32'h200, 32'h200);
    clear_in();
    flush_cycle("ecall");

    // Count saturates at 3 on the 2-bit instance from here on.
    instr_valid_i = 1; exc_ebreak_i = 1; exc_store_misalign_i = 1; pc_i = 32'h48;
    trap_cycle("ebreak", 32'd3, 32'h48, 32'h48, 32'h200, 32'h200);
    clear_in();
    flush_cycle("ebreak");

    instr_valid_i = 1; exc_fetch_misalign_i = 1; exc_illegal_i = 1; bad_addr_i = 32'h502; pc_i = 32'h4C;
    trap_cycle("fetchmis", 32'd0, 32'h502, 32'h4C, 32'h200, 32'h200);
    clear_in();
    flush_cycle("fetchmis");

    instr_valid_i = 1; exc_store_misalign_i = 1; bad_addr_i = 32'h601; pc_i = 32'h50;
    trap_cycle("storemis", 32'd6, 32'h601, 32'h50, 32'h200, 32'h200);
    clear_in();
    flush_cycle("storemis");

    // WFI: commits, stalls with no strobes, wakes on the timer interrupt.
    instr_valid_i = 1; wfi_i = 1; pc_i = 32'h80; next_pc_i = 32'h84;
    #1;
    check("wfi_commit_jump",  32'(jump),  32'd0);
    check("wfi_commit_flush", 32'(flush), 32'd0);
    tick();
    clear_in();
    next_pc_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("wfi_stall", 32'(stall), 32'd1);
      check("wfi_strobe", {29'd0, jump, redir, flush}, 32'd0);
      tick();
    end
    mtime_exc_i = 1;
    trap_cycle("wfi_wake", 32'h8000_0007, 32'd0, 32'h84, 32'h21C, 32'h200);
    mtime_exc_i = 0;
    flush_cycle("wfi_wake");
    #1;
    check("wfi_run_flush", 32'(flush), 32'd0);
    check("wfi_run_stall", 32'(stall), 32'd0);
    tick();

    // MRET alone, then MRET losing to a load misalign.
    instr_valid_i = 1; mret_i = 1; mepc_i = 32'h1234; pc_i = 32'h90;
    #1;
    check("mret_redir", 32'(redir), 32'd1);
    check("mret_rpc",   rpc, 32'h1234);
    check("mret_jump",  32'(jump), 32'd0);
    check("mret_flush", 32'(flush), 32'd1);
    check("mret_tpc",   tpc, 32'd0);
    tick();
    check_counts("mret");
    clear_in();
    flush_cycle("mret");
    instr_valid_i = 1; mret_i = 1; exc_load_misalign_i = 1; bad_addr_i = 32'h1003; pc_i = 32'h94;
    trap_cycle("mret_ld", 32'd4, 32'h1003, 32'h94, 32'h200, 32'h200);
    clear_in();
    flush_cycle("mret_ld");

    // Interrupt pending without a boundary is not taken.
    mtime_exc_i = 1; pc_i = 32'hA0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("irq_nobnd_jump", 32'(jump), 32'd0);
      tick();
    end
    instr_valid_i = 1;
    trap_cycle("irq_bnd", 32'h8000_0007, 32'd0, 32'hA0, 32'h21C, 32'h200);
    clear_in();
    flush_cycle("irq_bnd");

    // WFI with interrupt: interrupt wins, no WFI entered.
    instr_valid_i = 1; wfi_i = 1; mtime_exc_i = 1; pc_i = 32'hB0; next_pc_i = 32'hB4;
    trap_cycle("wfi_irq", 32'h8000_0007, 32'd0, 32'hB0, 32'h21C, 32'h200);
    clear_in();
    flush_cycle("wfi_irq");
    #1;
    check("wfi_irq_stall", 32'(stall), 32'd0);
    tick();

    // Reset while in WFI returns to RUN with counters cleared.
    instr_valid_i = 1; wfi_i = 1; pc_i = 32'hC0; next_pc_i = 32'hC4;
    tick();
    clear_in();
    #1;
    check("wfirst_stall_pre", 32'(stall), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    exp_cnt = 0; exp_cnt0 = 0;
    #1;
    check("wfirst_stall", 32'(stall), 32'd0);
    check("wfirst_flush", 32'(flush), 32'd0);
    check_counts("wfirst");
    instr_valid_i = 1; exc_illegal_i = 1; pc_i = 32'hD0; instr_i = 32'h0000_0013;
    trap_cycle("post_rst", 32'd2, 32'h0000_0013, 32'hD0, 32'h200, 32'h200);
    clear_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
